// File: rtl/line_rasterizer_pkg.sv
// Shared types and constants for the line rasterizer and its step datapath.
package line_rasterizer_pkg;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } screenXY;

  typedef logic [2:0] color_t;

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} line_state_t;

  // Default visible screen size; the top-level parameters default to these.
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

endpackage

// File: rtl/line_rasterizer_step.sv
// line_step: one combinational Bresenham step (next point and next error term).
module line_step
  import line_rasterizer_pkg::*;
(
  input  screenXY            i_cur,
  input  logic signed [11:0] i_err,
  input  logic signed [11:0] i_dx,
  input  logic signed [11:0] i_dy,
  input  logic               i_sx_pos,
  input  logic               i_sy_pos,
  output screenXY            o_nxt,
  output logic signed [11:0] o_err
);

  logic signed [12:0] w_e2;
  logic signed [12:0] w_dx13;
  logic signed [12:0] w_dy13;
  logic               w_step_x;
  logic               w_step_y;

  assign w_e2     = $signed({i_err, 1'b0});
  assign w_dx13   = {i_dx[11], i_dx};
  assign w_dy13   = {i_dy[11], i_dy};
  assign w_step_x = (w_e2 >= w_dy13);
  assign w_step_y = (w_e2 <= w_dx13);

  // Apply the x and/or y move; both may fire in the same step on diagonals.
  always_comb begin
    o_nxt = i_cur;
    o_err = i_err;
    if (w_step_x) begin
      o_err   = o_err + i_dy;
      o_nxt.x = i_sx_pos ? i_cur.x + 10'd1 : i_cur.x - 10'd1;
    end
    if (w_step_y) begin
      o_err   = o_err + i_dx;
      o_nxt.y = i_sy_pos ? i_cur.y + 10'd1 : i_cur.y - 10'd1;
    end
  end

endmodule

// File: rtl/line_rasterizer.sv
// line_rasterizer: Bresenham line drawer, one pixel write per accepted beat.
// Optional macro LINE_CLIP_EN: off-screen points are stepped over silently.
module line_rasterizer
  import line_rasterizer_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic    Clk,
  input  logic    Reset,
  input  logic    cmd_valid,
  output logic    cmd_ready,
  input  screenXY cmd_p0,
  input  screenXY cmd_p1,
  input  color_t  cmd_color,
  output logic    pix_valid,
  input  logic    pix_ready,
  output screenXY pix_coords,
  output color_t  pix_color,
  output logic    busy
);

`ifdef LINE_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif
  localparam logic [10:0] LIM_W = 11'(SCREEN_W);
  localparam logic [10:0] LIM_H = 11'(SCREEN_H);

  line_state_t        r_state;
  screenXY            r_cur;
  screenXY            r_p1;
  color_t             r_color;
  logic signed [11:0] r_dx;
  logic signed [11:0] r_dy;
  logic signed [11:0] r_err;
  logic               r_sx_pos;
  logic               r_sy_pos;
  logic               r_pix_valid;

  logic signed [11:0] w_dx_raw;
  logic signed [11:0] w_dy_raw;
  logic signed [11:0] w_dx_abs;
  logic signed [11:0] w_dy_neg;
  screenXY            w_nxt;
  logic signed [11:0] w_nerr;
  logic               w_cur_vis;
  logic               w_nxt_vis;
  logic               w_last;
  logic               w_adv;

  // Setup deltas: r_cur holds p0 during SETUP.
  assign w_dx_raw = $signed({2'b00, r_p1.x}) - $signed({2'b00, r_cur.x});
  assign w_dy_raw = $signed({2'b00, r_p1.y}) - $signed({2'b00, r_cur.y});
  assign w_dx_abs = (w_dx_raw < 0) ? -w_dx_raw : w_dx_raw;
  assign w_dy_neg = (w_dy_raw < 0) ? w_dy_raw : -w_dy_raw;

  line_step u_step (
    .i_cur    (r_cur),
    .i_err    (r_err),
    .i_dx     (r_dx),
    .i_dy     (r_dy),
    .i_sx_pos (r_sx_pos),
    .i_sy_pos (r_sy_pos),
    .o_nxt    (w_nxt),
    .o_err    (w_nerr)
  );

  // Visibility is always true when clipping is compiled out.
  assign w_cur_vis = !CLIP_EN || (({1'b0, r_cur.x} < LIM_W) && ({1'b0, r_cur.y} < LIM_H));
  assign w_nxt_vis = !CLIP_EN || (({1'b0, w_nxt.x} < LIM_W) && ({1'b0, w_nxt.y} < LIM_H));
  assign w_last    = (r_cur == r_p1);
  // A presented point advances on handshake; a hidden (clipped) point advances unconditionally.
  assign w_adv     = (r_state == DRAW) && (r_pix_valid ? pix_ready : 1'b1);

  assign cmd_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign pix_valid  = r_pix_valid;
  assign pix_coords = r_cur;
  assign pix_color  = r_color;

  // Command FSM: latch, set up deltas, then walk the line one point per advance.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_cur       <= '0;
      r_p1        <= '0;
      r_color     <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_err       <= '0;
      r_sx_pos    <= 1'b0;
      r_sy_pos    <= 1'b0;
      r_pix_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_cur   <= cmd_p0;
            r_p1    <= cmd_p1;
            r_color <= cmd_color;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_dx        <= w_dx_abs;
          r_dy        <= w_dy_neg;
          r_err       <= w_dx_abs + w_dy_neg;
          r_sx_pos    <= (r_cur.x < r_p1.x);
          r_sy_pos    <= (r_cur.y < r_p1.y);
          r_pix_valid <= w_cur_vis;
          r_state     <= DRAW;
        end
        DRAW: begin
          if (w_adv) begin
            if (w_last) begin
              r_pix_valid <= 1'b0;
              r_state     <= IDLE;
            end else begin
              r_cur       <= w_nxt;
              r_err       <= w_nerr;
              r_pix_valid <= w_nxt_vis;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
